// File: rtl/pet2001_keyscan.sv
// pet2001_keyscan: PET 2001 keyboard matrix scanner with per-row debounce and PIA read port.
// Latency: row period SETTLE+1 cycles; ROW_SEL -> COL_OUT and array -> ANY_KEY are 1 cycle.
// Backpressure: none; SCAN_EN=0 parks the scanner in IDLE after the row in flight is sampled.
// Build option: define PET_KEYSCAN_DEBOUNCE_EN to compile in the DEBOUNCE-frame filter;
// without it every SAMPLE writes the raw column byte straight into the array.
module pet2001_keyscan #(
  parameter int ROWS     = 10,
  parameter int COLS     = 8,
  parameter int SETTLE   = 100,
  parameter int DEBOUNCE = 4
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            SCAN_EN,
  output logic [ROWS-1:0] KEYROW,
  input  logic [COLS-1:0] KEYCOL,
  input  logic [3:0]      ROW_SEL,
  output logic [COLS-1:0] COL_OUT,
  output logic            FRAME_DONE,
  output logic            ANY_KEY
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE} state_t;

  state_t          r_state, w_state_nxt;
  logic [RW-1:0]   r_row, w_row_nxt, w_row_inc;
  logic [SW-1:0]   r_settle;
  logic [ROWS-1:0] r_keyrow, w_keyrow_nxt, w_drive_mask;
  logic            r_frame_done, w_frame_done_nxt;
  logic            w_last_row, w_settle_done, w_sample;
  logic [COLS-1:0] r_sync1, r_sync2;
  logic [COLS-1:0] r_array [ROWS];
  logic [COLS-1:0] r_col_out;
  logic            r_any_key;
  logic            w_all_up;
  logic            w_wr_en;
  logic [COLS-1:0] w_wr_dat;

  assign w_last_row    = (r_row == RW'(ROWS - 1));
  assign w_row_inc     = w_last_row ? '0 : r_row + RW'(1);
  assign w_settle_done = (r_state == S_DRIVE) && (r_settle == SW'(SETTLE - 1));
  assign w_sample      = (r_state == S_SAMPLE);
  assign w_drive_mask  = ~({{(ROWS-1){1'b0}}, 1'b1} << w_row_nxt);

  // Next-state, next row index and registered strobe/pulse values.
  always_comb begin
    w_state_nxt      = r_state;
    w_row_nxt        = r_row;
    w_keyrow_nxt     = r_keyrow;
    w_frame_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (SCAN_EN) w_state_nxt = S_DRIVE;
      end
      S_DRIVE: begin
        if (w_settle_done) w_state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        // Index always advances so a parked scan resumes on the following row.
        w_row_nxt = w_row_inc;
        if (SCAN_EN) begin
          w_state_nxt      = S_DRIVE;
          w_frame_done_nxt = w_last_row;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_state_nxt == S_DRIVE && r_state != S_DRIVE) w_keyrow_nxt = w_drive_mask;
    else if (w_state_nxt == S_IDLE) w_keyrow_nxt = '1;
  end

  // Scanner state, row index, settle counter and registered strobes.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_settle     <= '0;
      r_keyrow     <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_row        <= w_row_nxt;
      r_settle     <= (r_state == S_DRIVE && !w_settle_done) ? r_settle + SW'(1) : '0;
      r_keyrow     <= w_keyrow_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  // Two-flop synchronizer for the asynchronous column returns.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= KEYCOL;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PET_KEYSCAN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [COLS-1:0] r_last [ROWS];
  logic [CW-1:0]   r_cnt  [ROWS];
  logic [COLS-1:0] w_last_nxt;
  logic [CW-1:0]   w_cnt_nxt;

  // Stability tracking for the row being sampled; array commits when the count hits DEBOUNCE.
  always_comb begin
    w_last_nxt = r_last[r_row];
    w_cnt_nxt  = r_cnt[r_row];
    if (r_sync2 != r_last[r_row]) begin
      w_last_nxt = r_sync2;
      w_cnt_nxt  = CW'(1);
    end else if (r_cnt[r_row] < CW'(DEBOUNCE)) begin
      w_cnt_nxt = r_cnt[r_row] + CW'(1);
    end
    w_wr_en  = w_sample && (w_cnt_nxt == CW'(DEBOUNCE));
    w_wr_dat = w_last_nxt;
  end

  // Per-row last-raw byte and saturating stability counter.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int r = 0; r < ROWS; r++) begin
        r_last[r] <= '1;
        r_cnt[r]  <= '0;
      end
    end else if (w_sample) begin
      r_last[r_row] <= w_last_nxt;
      r_cnt[r_row]  <= w_cnt_nxt;
    end
  end
`else
  // Without the filter each sample is committed as-is.
  always_comb begin
    w_wr_en  = w_sample;
    w_wr_dat = r_sync2;
  end
`endif

  // Key-state array: one byte per row, written only in that row's SAMPLE cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int r = 0; r < ROWS; r++) r_array[r] <= '1;
    end else if (w_wr_en) begin
      r_array[r_row] <= w_wr_dat;
    end
  end

  // AND of every array bit; any zero means a key is down.
  always_comb begin
    w_all_up = 1'b1;
    for (int r = 0; r < ROWS; r++) w_all_up = w_all_up & (&r_array[r]);
  end

  // Registered read port: a same-cycle write shows up on the following cycle, whole byte at once.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_col_out <= '1;
      r_any_key <= 1'b0;
    end else begin
      if ({1'b0, ROW_SEL} < 5'(ROWS)) r_col_out <= r_array[ROW_SEL];
      else                            r_col_out <= '1;
      r_any_key <= ~w_all_up;
    end
  end

  assign KEYROW     = r_keyrow;
  assign COL_OUT    = r_col_out;
  assign FRAME_DONE = r_frame_done;
  assign ANY_KEY    = r_any_key;

endmodule
